cache_controller: RTL and testbench

- Sequences the direct-mapped read cache: 15-bit address, split as tag[14:12], index[11:2] and word offset[1:0], with 128-bit block fill and a 32-bit read word.
- Accepts single-word CPU read requests, checks hit/miss through the cache's combinational hit output, and on a miss fetches the 128-bit block from main memory through a ready handshake.
- Writes the fetched block into the cache, then returns the word to the CPU.
- Keeps access and hit statistics counters for hit-rate measurement.

---
 rtl/cache_pkg.sv | 21 ++
 rtl/stat_counter.sv | 22 ++
 rtl/cache_controller.sv | 131 +++++++++++++
 tb/tb_cache_controller.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared widths and FSM encoding for the direct-mapped read cache controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cache_pkg;

  localparam int ADR_W  = 15;
  localparam int TAG_W  = 3;
  localparam int IDX_W  = 10;
  localparam int OFF_W  = 2;
  localparam int BLK_W  = 128;
  localparam int WORD_W = 32;

  // Two-bit encoding; all four codes are live states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    FETCH   = 2'd2,
    FILL    = 2'd3
  } state_t;

endpackage

// File: rtl/stat_counter.sv
// Free-running statistics counter that wraps silently on overflow.
// Latency: count reflects an inc pulse one cycle later.
// Backpressure: none; every inc pulse is counted.
module stat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Increment on request; wrap from all-ones to zero with no sticky flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Sequences CPU reads through a direct-mapped cache, fetching and filling a block on a miss.
// Latency: hit returns cpu_ready 2 cycles after acceptance; miss 4 + (FETCH cycles incl. the mem_ready cycle).
// Backpressure: one request in flight; cpu_read while busy is dropped, memory stalls FETCH via mem_ready.
module cache_controller
  import cache_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_read,
  input  logic [ADR_W-1:0]   cpu_adr,
  output logic               cpu_ready,
  output logic [WORD_W-1:0]  cpu_data,
  output logic               cpu_busy,
  output logic [ADR_W-1:0]   cache_adr,
  output logic               cache_write,
  output logic [BLK_W-1:0]   cache_wblock,
  input  logic [WORD_W-1:0]  cache_rdata,
  input  logic               cache_hit,
  output logic               mem_read,
  output logic [ADR_W-1:0]   mem_adr,
  input  logic               mem_ready,
  input  logic [BLK_W-1:0]   mem_data,
  output logic [CNT_W-1:0]   access_count,
  output logic [CNT_W-1:0]   hit_count
);

  state_t             state;
  state_t             state_nxt;
  logic [ADR_W-1:0]   adr_q;
  logic [BLK_W-1:0]   blk_q;
  logic               first_q;
  logic               acc_inc;
  logic               hit_inc;
  logic               accept;
  logic               hit_return;

  assign accept     = (state == IDLE) && cpu_read;
  assign hit_return = (state == COMPARE) && cache_hit;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and counter strobes; a post-fill miss simply loops back to FETCH.
  always_comb begin
    state_nxt = state;
    acc_inc   = 1'b0;
    hit_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_read) begin
          state_nxt = COMPARE;
          acc_inc   = 1'b1;
        end
      end
      COMPARE: begin
        if (cache_hit) begin
          state_nxt = IDLE;
          hit_inc   = first_q;
        end else begin
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (mem_ready) begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        state_nxt = COMPARE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request latch, block buffer, first-compare flag and registered CPU return.
  always_ff @(posedge clk) begin
    if (rst) begin
      adr_q     <= '0;
      blk_q     <= '0;
      first_q   <= 1'b0;
      cpu_ready <= 1'b0;
      cpu_data  <= '0;
    end else begin
      cpu_ready <= hit_return;
      if (hit_return) begin
        cpu_data <= cache_rdata;
      end
      if (accept) begin
        adr_q   <= cpu_adr;
        first_q <= 1'b1;
      end else if (state == FILL) begin
        first_q <= 1'b0;
      end
      if ((state == FETCH) && mem_ready) begin
        blk_q <= mem_data;
      end
    end
  end

  assign mem_read     = (state == FETCH);
  assign cache_write  = (state == FILL);
  assign cpu_busy     = (state != IDLE);
  assign cache_wblock = blk_q;
  assign cache_adr    = adr_q;
  assign mem_adr      = {adr_q[ADR_W-1:OFF_W], {OFF_W{1'b0}}};

  stat_counter #(.W(CNT_W)) u_access_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (acc_inc),
    .count (access_count)
  );

  stat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .count (hit_count)
  );

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a behavioural cache array and memory responder.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_cache_controller;

  logic         clk;
  logic         rst;
  logic         cpu_read;
  logic [14:0]  cpu_adr;
  logic         cpu_ready;
  logic [31:0]  cpu_data;
  logic         cpu_busy;
  logic [14:0]  cache_adr;
  logic         cache_write;
  logic [127:0] cache_wblock;
  logic [31:0]  cache_rdata;
  logic         cache_hit;
  logic         mem_read;
  logic [14:0]  mem_adr;
  logic         mem_ready;
  logic [127:0] mem_data;
  logic [15:0]  access_count;
  logic [15:0]  hit_count;

  logic         w4_ready;
  logic [31:0]  w4_data;
  logic         w4_busy;
  logic [14:0]  w4_cache_adr;
  logic         w4_cache_write;
  logic [127:0] w4_wblock;
  logic         w4_mem_read;
  logic [14:0]  w4_mem_adr;
  logic [3:0]   w4_access;
  logic [3:0]   w4_hit;

  int errors = 0;
  int checks = 0;

  cache_controller #(.CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .cpu_read(cpu_read), .cpu_adr(cpu_adr),
    .cpu_ready(cpu_ready), .cpu_data(cpu_data), .cpu_busy(cpu_busy),
    .cache_adr(cache_adr), .cache_write(cache_write), .cache_wblock(cache_wblock),
    .cache_rdata(cache_rdata), .cache_hit(cache_hit),
    .mem_read(mem_read), .mem_adr(mem_adr), .mem_ready(mem_ready), .mem_data(mem_data),
    .access_count(access_count), .hit_count(hit_count)
  );

  // Narrow-counter instance in lockstep with the main one (identical inputs).
  cache_controller #(.CNT_W(4)) u_dut_w4 (
    .clk(clk), .rst(rst), .cpu_read(cpu_read), .cpu_adr(cpu_adr),
    .cpu_ready(w4_ready), .cpu_data(w4_data), .cpu_busy(w4_busy),
    .cache_adr(w4_cache_adr), .cache_write(w4_cache_write), .cache_wblock(w4_wblock),
    .cache_rdata(cache_rdata), .cache_hit(cache_hit),
    .mem_read(w4_mem_read), .mem_adr(w4_mem_adr), .mem_ready(mem_ready), .mem_data(mem_data),
    .access_count(w4_access), .hit_count(w4_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural direct-mapped cache: combinational lookup, block write on clock edge.
  logic         c_valid [1024];
  logic [2:0]   c_tag   [1024];
  logic [127:0] c_data  [1024];

  initial begin
    for (int i = 0; i < 1024; i++) begin
      c_valid[i] = 1'b0;
      c_tag[i]   = '0;
      c_data[i]  = '0;
    end
  end

  assign cache_hit   = c_valid[cache_adr[11:2]] && (c_tag[cache_adr[11:2]] == cache_adr[14:12]);
  assign cache_rdata = c_data[cache_adr[11:2]][cache_adr[1:0]*32 +: 32];

  always @(posedge clk) begin
    if (cache_write) begin
      c_valid[cache_adr[11:2]] <= 1'b1;
      c_tag[cache_adr[11:2]]   <= cache_adr[14:12];
      c_data[cache_adr[11:2]]  <= cache_wblock;
    end
  end

  // Issue one read; memory answers on the f-th FETCH cycle. Cycle 1 is the first cycle after the accepting edge.
  task automatic do_read(input logic [14:0] adr, input int f, input logic [127:0] blk, input bit intrude,
                         output int rdy_cyc, output int rdy_n, output int reads, output int writes,
                         output logic [31:0] data);
    int fetch_n;
    rdy_cyc = -1; rdy_n = 0; reads = 0; writes = 0; data = '0; fetch_n = 0;
    cpu_adr  = adr;
    cpu_read = 1'b1;
    @(posedge clk); #1;
    cpu_read = 1'b0;
    for (int cyc = 1; cyc < 40; cyc++) begin
      mem_ready = 1'b0;
      mem_data  = {4{32'hDEADBEEF}};
      if (mem_read) begin
        reads++;
        fetch_n++;
        checks++;
        if (mem_adr !== {adr[14:2], 2'b00}) begin
          errors++;
          $display("FAIL mem_adr: got %h expected %h", mem_adr, {adr[14:2], 2'b00});
        end
        if (fetch_n == f) begin
          mem_ready = 1'b1;
          mem_data  = blk;
        end
        if (intrude) begin
          cpu_read = 1'b1;
          cpu_adr  = 15'h7FFC;
        end
      end else begin
        cpu_read = 1'b0;
        cpu_adr  = adr;
      end
      if (cache_write) begin
        writes++;
        checks++;
        if (cache_wblock !== blk) begin
          errors++;
          $display("FAIL cache_wblock: got %h expected %h", cache_wblock, blk);
        end
      end
      if (cpu_ready) begin
        rdy_n++;
        if (rdy_cyc < 0) begin
          rdy_cyc = cyc;
          data    = cpu_data;
        end
      end
      if (rdy_cyc > 0 && cyc >= rdy_cyc + 2) break;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    cpu_read  = 1'b0;
  endtask

  int          rc, rn, rd, wr;
  logic [31:0] dat;

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cpu_busy !== 1'b0)   begin errors++; $display("FAIL reset busy: got %b expected 0", cpu_busy); end
    checks++; if (cpu_ready !== 1'b0)  begin errors++; $display("FAIL reset ready: got %b expected 0", cpu_ready); end
    checks++; if (cpu_data !== 32'h0)  begin errors++; $display("FAIL reset data: got %h expected 0", cpu_data); end
    checks++; if (mem_read !== 1'b0 || cache_write !== 1'b0) begin errors++; $display("FAIL reset strobes: got mem_read=%b cache_write=%b expected 0 0", mem_read, cache_write); end
    checks++; if (cache_wblock !== 128'h0) begin errors++; $display("FAIL reset wblock: got %h expected 0", cache_wblock); end
    checks++; if (access_count !== 16'd0 || hit_count !== 16'd0) begin errors++; $display("FAIL reset counters: got %0d/%0d expected 0/0", access_count, hit_count); end
    rst = 1'b0;
  endtask

  task automatic test_cold_miss();
    do_read(15'h1235, 3, 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000, 1'b0, rc, rn, rd, wr, dat);
    checks++; if (rd !== 3)                   begin errors++; $display("FAIL cold mem_read cycles: got %0d expected 3", rd); end
    checks++; if (wr !== 1)                   begin errors++; $display("FAIL cold cache_write cycles: got %0d expected 1", wr); end
    checks++; if (rc !== 7)                   begin errors++; $display("FAIL cold ready cycle: got %0d expected 7", rc); end
    checks++; if (rn !== 1)                   begin errors++; $display("FAIL cold ready pulses: got %0d expected 1", rn); end
    checks++; if (dat !== 32'hBBBB0001)       begin errors++; $display("FAIL cold data: got %h expected BBBB0001", dat); end
    checks++; if (access_count !== 16'd1 || hit_count !== 16'd0) begin errors++; $display("FAIL cold counters: got %0d/%0d expected 1/0", access_count, hit_count); end
  endtask

  task automatic test_hit();
    do_read(15'h1236, 1, 128'h0, 1'b0, rc, rn, rd, wr, dat);
    checks++; if (rd !== 0)                   begin errors++; $display("FAIL hit mem_read cycles: got %0d expected 0", rd); end
    checks++; if (rc !== 2)                   begin errors++; $display("FAIL hit ready cycle: got %0d expected 2", rc); end
    checks++; if (rn !== 1)                   begin errors++; $display("FAIL hit ready pulses: got %0d expected 1", rn); end
    checks++; if (dat !== 32'hCCCC0002)       begin errors++; $display("FAIL hit data: got %h expected CCCC0002", dat); end
    checks++; if (cpu_data !== 32'hCCCC0002)  begin errors++; $display("FAIL hit data hold: got %h expected CCCC0002", cpu_data); end
    checks++; if (access_count !== 16'd2 || hit_count !== 16'd1) begin errors++; $display("FAIL hit counters: got %0d/%0d expected 2/1", access_count, hit_count); end
  endtask

  task automatic test_conflict();
    do_read(15'h5234, 1, {4{32'h11111111}}, 1'b0, rc, rn, rd, wr, dat);
    checks++; if (rd !== 1)                   begin errors++; $display("FAIL conflict mem_read cycles: got %0d expected 1", rd); end
    checks++; if (rc !== 5)                   begin errors++; $display("FAIL conflict ready cycle: got %0d expected 5", rc); end
    checks++; if (dat !== 32'h11111111)       begin errors++; $display("FAIL conflict data: got %h expected 11111111", dat); end
    checks++; if (access_count !== 16'd3 || hit_count !== 16'd1) begin errors++; $display("FAIL conflict counters: got %0d/%0d expected 3/1", access_count, hit_count); end
    do_read(15'h1235, 2, 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000, 1'b0, rc, rn, rd, wr, dat);
    checks++; if (rd !== 2)                   begin errors++; $display("FAIL reread mem_read cycles: got %0d expected 2", rd); end
    checks++; if (rc !== 6)                   begin errors++; $display("FAIL reread ready cycle: got %0d expected 6", rc); end
    checks++; if (dat !== 32'hBBBB0001)       begin errors++; $display("FAIL reread data: got %h expected BBBB0001", dat); end
    checks++; if (access_count !== 16'd4 || hit_count !== 16'd1) begin errors++; $display("FAIL reread counters: got %0d/%0d expected 4/1", access_count, hit_count); end
  endtask

  task automatic test_busy_ignore();
    do_read(15'h0012, 3, 128'h44444444_33333333_22222222_11111111, 1'b1, rc, rn, rd, wr, dat);
    checks++; if (rc !== 7)                   begin errors++; $display("FAIL busy ready cycle: got %0d expected 7", rc); end
    checks++; if (rn !== 1)                   begin errors++; $display("FAIL busy ready pulses: got %0d expected 1", rn); end
    checks++; if (dat !== 32'h33333333)       begin errors++; $display("FAIL busy data: got %h expected 33333333", dat); end
    checks++; if (cpu_busy !== 1'b0)          begin errors++; $display("FAIL busy idle after: got %b expected 0", cpu_busy); end
    checks++; if (access_count !== 16'd5 || hit_count !== 16'd1) begin errors++; $display("FAIL busy counters: got %0d/%0d expected 5/1", access_count, hit_count); end
  endtask

  task automatic test_reset_mid_fetch();
    cpu_adr  = 15'h2000;
    cpu_read = 1'b1;
    @(posedge clk); #1;
    cpu_read = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (mem_read !== 1'b1)          begin errors++; $display("FAIL midrst in fetch: got %b expected 1", mem_read); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (mem_read !== 1'b0)          begin errors++; $display("FAIL midrst mem_read: got %b expected 0", mem_read); end
    checks++; if (cpu_busy !== 1'b0)          begin errors++; $display("FAIL midrst busy: got %b expected 0", cpu_busy); end
    checks++; if (cpu_ready !== 1'b0 || cpu_data !== 32'h0) begin errors++; $display("FAIL midrst cpu: got ready=%b data=%h expected 0 0", cpu_ready, cpu_data); end
    checks++; if (access_count !== 16'd0 || hit_count !== 16'd0 || w4_access !== 4'd0 || w4_hit !== 4'd0) begin errors++; $display("FAIL midrst counters: got %0d/%0d %0d/%0d expected zeros", access_count, hit_count, w4_access, w4_hit); end
    mem_ready = 1'b1;
    mem_data  = {4{32'h99999999}};
    @(posedge clk); #1;
    mem_ready = 1'b0;
    checks++; if (cpu_busy !== 1'b0 || cache_write !== 1'b0) begin errors++; $display("FAIL stray ready: got busy=%b write=%b expected 0 0", cpu_busy, cache_write); end
    @(posedge clk); #1;
    checks++; if (cpu_busy !== 1'b0 || cache_write !== 1'b0 || cpu_ready !== 1'b0) begin errors++; $display("FAIL stray ready later: got busy=%b write=%b ready=%b expected 0 0 0", cpu_busy, cache_write, cpu_ready); end
  endtask

  task automatic test_wrap();
    do_read(15'h3000, 2, 128'h30000003_30000002_30000001_30000000, 1'b0, rc, rn, rd, wr, dat);
    checks++; if (dat !== 32'h30000000)       begin errors++; $display("FAIL wrap miss data: got %h expected 30000000", dat); end
    for (int i = 0; i < 17; i++) begin
      do_read(15'h3000 | 15'(i % 4), 1, 128'h0, 1'b0, rc, rn, rd, wr, dat);
    end
    checks++; if (dat !== 32'h30000000)       begin errors++; $display("FAIL wrap last hit data: got %h expected 30000000", dat); end
    checks++; if (access_count !== 16'd18 || hit_count !== 16'd17) begin errors++; $display("FAIL wide counters: got %0d/%0d expected 18/17", access_count, hit_count); end
    checks++; if (w4_access !== 4'd2)         begin errors++; $display("FAIL wrap access_count: got %0d expected 2", w4_access); end
    checks++; if (w4_hit !== 4'd1)            begin errors++; $display("FAIL wrap hit_count: got %0d expected 1", w4_hit); end
  endtask

  initial begin
    rst       = 1'b1;
    cpu_read  = 1'b0;
    cpu_adr   = '0;
    mem_ready = 1'b0;
    mem_data  = '0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_busy_ignore();
    test_reset_mid_fetch();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
